riscv_dmem_ctrl: RTL and testbench

Parametrised data-memory controller for the 5-stage core. It replaces the flat word-only data array with a valid/ready request port, configurable wait states, and byte/halfword/word loads and stores with sign or zero extension. It also reports errors for out-of-range accesses. It sits between the core's MEM stage and an internal word-organised RAM.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/riscv_lsu_align.sv | 67 ++++++
 rtl/riscv_dmem_ctrl.sv | 140 ++++++++++++++
 tb/tb_riscv_dmem_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the data-memory controller: access sizes and controller FSM states.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_B    = 2'b00,
    MEM_H    = 2'b01,
    MEM_W    = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store byte-enables and lane replication, load
// lane extraction with sign/zero extension. Offset arrives already aligned.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  mem_size_e   w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic zext);
    return zext ? {24'd0, v} : {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic zext);
    return zext ? {16'd0, v} : {{16{v[15]}}, v};
  endfunction

  assign w_size = mem_size_e'(i_size);
  assign w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    w_byte = i_rword[7:0];
    case (i_off)
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = i_rword[7:0];
    endcase
  end

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = 32'd0;
    case (w_size)
      MEM_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = ext8(w_byte, i_unsigned);
      end
      MEM_H: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = ext16(w_half, i_unsigned);
      end
      MEM_W: begin
        o_be    = 4'b1111;
        o_rdata = i_rword;
      end
      default: begin
        o_be    = 4'b0000;
        o_rdata = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller: valid/ready request port, WAIT_STATES wait cycles,
// sized loads/stores. Define RISCV_DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module riscv_dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_we, r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;
  logic        r_rsp_valid, r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept, w_acc, w_we, w_uns, w_err, w_err_mis, w_wr;
  mem_size_e   w_size;
  logic [31:0] w_addr, w_wdata, w_rword, w_wdata_lane, w_rdata_ext;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [AW-1:0] w_idx;

  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  // Zero wait states accesses straight from the port; otherwise from the captured request.
  assign w_we    = (WAIT_STATES == 0) ? req_we       : r_we;
  assign w_uns   = (WAIT_STATES == 0) ? req_unsigned : r_uns;
  assign w_size  = mem_size_e'((WAIT_STATES == 0) ? req_size : r_size);
  assign w_addr  = (WAIT_STATES == 0) ? req_addr     : r_addr;
  assign w_wdata = (WAIT_STATES == 0) ? req_wdata    : r_wdata;
  assign w_acc   = (WAIT_STATES == 0) ? w_accept
                 : ((r_state == WAIT) && (r_cnt == 4'd0) && !rst);

`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
  assign w_err_mis = ((w_size == MEM_H) && w_addr[0]) ||
                     ((w_size == MEM_W) && (w_addr[1:0] != 2'b00));
  assign w_off     = w_addr[1:0];
`else
  assign w_err_mis = 1'b0;
  assign w_off     = (w_size == MEM_W) ? 2'b00
                   : (w_size == MEM_H) ? {w_addr[1], 1'b0} : w_addr[1:0];
`endif

  assign w_err   = (w_size == MEM_RSVD) || (w_addr[31:2] >= 30'(DEPTH_WORDS)) || w_err_mis;
  assign w_idx   = w_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];
  assign w_wr    = w_acc && w_we && !w_err;

  riscv_lsu_align u_align (
    .i_size     (w_size),
    .i_off      (w_off),
    .i_unsigned (w_uns),
    .i_wdata    (w_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata_lane),
    .o_rdata    (w_rdata_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_accept && (WAIT_STATES != 0)) begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = WS_INIT;
      end
      WAIT: if (r_cnt == 4'd0) w_state_nxt = IDLE;
            else               w_cnt_nxt   = r_cnt - 4'd1;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_acc;
      if (w_acc) begin
        r_rsp_rdata <= (w_we || w_err) ? 32'd0 : w_rdata_ext;
        r_rsp_err   <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Scoreboard bench for riscv_dmem_ctrl: one instance with zero wait states,
// one with three, each checked against a byte-addressed reference memory.
module tb_riscv_dmem_ctrl;

  localparam int DEPTH = 64;
  localparam int WS1   = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];

  logic [7:0]  mem [2][DEPTH*4];
  exp_t        q0[$];
  exp_t        q1[$];
  int          ncnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  riscv_dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  riscv_dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Reference: memory is a flat byte array; an access touches 1, 2 or 4 bytes.
  task automatic model(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int nb, a;
    logic [31:0] v;
    er = (sz == 2'd3) || (addr / 4 >= DEPTH);
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
    if (sz == 2'd1 && addr % 2 != 0) er = 1'b1;
    if (sz == 2'd2 && addr % 4 != 0) er = 1'b1;
`endif
    rd = 32'd0;
    if (er) return;
    nb = 1 << sz;
    a  = int'(addr) - (int'(addr) % nb);
    v  = 32'd0;
    for (int i = 0; i < nb; i++) begin
      if (we) mem[d][a+i] = wd[8*i +: 8];
      else    v[8*i +: 8] = mem[d][a+i];
    end
    if (we) return;
    if (nb < 4 && !uns && v[8*nb-1]) begin
      for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
    end
    rd = v;
  endtask

  task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit track);
    int guard = 0;
    exp_t e;
    logic [31:0] rd;
    logic er;
    @(negedge clk); #1;
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
    req_unsigned[d] = uns; req_addr[d] = addr; req_wdata[d] = wd;
    while (!req_ready[d]) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 100) begin
        $display("FAIL ready_timeout: dut%0d req_ready stuck at 0 expected 1", d);
        $fatal(1, "ready timeout");
      end
    end
    if (track) begin
      model(d, we, sz, uns, addr, wd, rd, er);
      e.rdata = rd; e.err = er; e.due = ncnt + 1 + (d == 1 ? WS1 : 0);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    ncnt++;
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d]) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          chk($sformatf("unexpected_rsp_dut%0d", d), 32'd1, 32'd0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("rsp_rdata_dut%0d", d), rsp_rdata[d], e.rdata);
          chk($sformatf("rsp_err_dut%0d", d), {31'd0, rsp_err[d]}, {31'd0, e.err});
          chk($sformatf("rsp_latency_dut%0d", d), ncnt, e.due);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", {31'd0, req_ready[d]}, 32'd0);
      chk("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("reset_rsp_err", {31'd0, rsp_err[d]}, 32'd0);
    end
    #1; rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("ready_after_reset0", {31'd0, req_ready[0]}, 32'd1);
    chk("ready_after_reset1", {31'd0, req_ready[1]}, 32'd1);

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++) issue(d, 1'b1, 2'd2, 1'b0, 32'(w*4), $urandom, 1'b1);

    for (int d = 0; d < 2; d++) begin
      issue(d, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
      issue(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
      issue(d, 1'b1, 2'd0, 1'b0, 32'h11, 32'h80, 1'b1);
      issue(d, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1);
      issue(d, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1);
      issue(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
      issue(d, 1'b0, 2'd2, 1'b0, 32'(4*DEPTH), 32'h0, 1'b1);
      issue(d, 1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, 1'b1);
      issue(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
      issue(d, 1'b1, 2'd1, 1'b0, 32'h13, 32'hA5C3, 1'b1);
      issue(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
      issue(d, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1);
    end

    // Wait-state window: ready stays low for the three cycles after acceptance.
    issue(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
    for (int k = 0; k < WS1; k++) begin
      @(negedge clk);
      chk("ready_low_in_wait", {31'd0, req_ready[1]}, 32'd0);
    end
    @(negedge clk);
    chk("ready_back_after_wait", {31'd0, req_ready[1]}, 32'd1);

    // Reset during WAIT abandons the store.
    issue(1, 1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFEF00D, 1'b0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", {31'd0, req_ready[1]}, 32'd1);
    repeat (6) @(negedge clk);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b1);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < (d == 0 ? 200 : 100); n++) begin
        issue(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, DEPTH*4 + 15)), $urandom, 1'b1);
      end
    end

    for (int k = 0; k < 50 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    chk("drain_dut0", q0.size(), 32'd0);
    chk("drain_dut1", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
